// File: rtl/hilo_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv_pkg
// Description : Operation codes, FSM encodings and HI/LO write-bundle width
//               shared by the HI/LO multiply/divide unit.
// Revision    : 1.0
// ============================================================================
package hilo_muldiv_pkg;

    localparam logic [2:0] MD_OP_NOP   = 3'd0;
    localparam logic [2:0] MD_OP_MULT  = 3'd1;
    localparam logic [2:0] MD_OP_MULTU = 3'd2;
    localparam logic [2:0] MD_OP_DIV   = 3'd3;
    localparam logic [2:0] MD_OP_DIVU  = 3'd4;
    localparam logic [2:0] MD_OP_MTHI  = 3'd5;
    localparam logic [2:0] MD_OP_MTLO  = 3'd6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // {hi_we, lo_we, hi_wdata, lo_wdata}
    localparam int HILO_WB_W = 66;

    function automatic logic md_is_mul(input logic [2:0] op);
        return (op == MD_OP_MULT) || (op == MD_OP_MULTU);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_OP_MULT) || (op == MD_OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv_div_core.sv
`default_nettype none
// ============================================================================
// Module      : div_core
// Description : Iterative unsigned restoring divider, one quotient bit per
//               cycle. A zero divisor yields quot=all-ones, rem=dividend.
// Revision    : 1.0
// ============================================================================
module div_core #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        abort,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quot,
    output logic [31:0] rem
);
    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(ITER - 1);

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_q;
    logic [31:0]      r_rem;
    logic [31:0]      r_dvsr;
    logic [32:0]      w_shift;
    logic [31:0]      w_diff;
    logic             w_ge;

    // 33-bit partial remainder: previous remainder with the next dividend bit
    assign w_shift = {r_rem, r_q[31]};
    assign w_ge    = (w_shift >= {1'b0, r_dvsr});
    // Only taken when w_ge, so the true difference always fits in 32 bits
    assign w_diff  = w_shift[31:0] - r_dvsr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_q    <= '0;
            r_rem  <= '0;
            r_dvsr <= '0;
        end else if (abort) begin
            r_busy <= 1'b0;
        end else if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_q    <= dividend;
            r_rem  <= '0;
            r_dvsr <= divisor;
        end else if (r_busy) begin
            r_q   <= {r_q[30:0], w_ge};
            r_rem <= w_ge ? w_diff : w_shift[31:0];
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == C_LAST) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign done = r_busy && (r_cnt == C_LAST);
    assign quot = r_q;
    assign rem  = r_rem;

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv
// Description : Multi-cycle MULT/MULTU/DIV/DIVU and single-cycle MTHI/MTLO
//               unit driving the HI/LO register-file write port.
//               Build option FAST_MUL_EN: single-cycle combinational multiply.
// Revision    : 1.0
// ============================================================================
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        stallreq,
    output logic        busy,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata
);
    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(ITER - 1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [63:0]          r_acc;
    logic [31:0]          r_mcand;
    logic                 r_neg;
    logic                 r_qneg;
    logic                 r_rneg;
    logic                 r_is_div;

    logic                 w_idle;
    logic                 w_go;
    logic                 w_mul_op;
    logic                 w_div_op;
    logic                 w_signed;
    logic [31:0]          w_abs_a;
    logic [31:0]          w_abs_b;
    logic [32:0]          w_mul_sum;
    logic                 w_div_start;
    logic                 w_div_done;
    logic [31:0]          w_quot;
    logic [31:0]          w_rem;
    logic [63:0]          w_prod;
    logic [31:0]          w_res_hi;
    logic [31:0]          w_res_lo;
    logic [HILO_WB_W-1:0] w_wb;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_go        = resetn && start && !flush && w_idle;
    assign w_mul_op    = md_is_mul(op);
    assign w_div_op    = md_is_div(op);
    assign w_signed    = md_is_signed(op);
    assign w_abs_a     = (w_signed && src_a[31]) ? (~src_a + 32'd1) : src_a;
    assign w_abs_b     = (w_signed && src_b[31]) ? (~src_b + 32'd1) : src_b;
    assign w_div_start = w_go && w_div_op;

    // Shift-add step: low half of the accumulator holds the remaining multiplier bits
    assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mcand} : 33'd0);

    div_core #(
        .ITER     (ITER)
    ) u_div_core (
        .clk      (clk),
        .resetn   (resetn),
        .abort    (flush),
        .start    (w_div_start),
        .dividend (w_abs_a),
        .divisor  (w_abs_b),
        .done     (w_div_done),
        .quot     (w_quot),
        .rem      (w_rem)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_neg    <= 1'b0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_is_div <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_go && w_mul_op) begin
                r_is_div <= 1'b0;
                r_neg    <= w_signed && (src_a[31] ^ src_b[31]);
                r_cnt    <= '0;
                r_mcand  <= w_abs_a;
`ifdef FAST_MUL_EN
                r_acc    <= {32'd0, w_abs_a} * {32'd0, w_abs_b};
`else
                r_acc    <= {32'd0, w_abs_b};
`endif
            end else if (w_div_start) begin
                r_is_div <= 1'b1;
                // Divide by zero keeps the all-ones quotient unsigned
                r_qneg   <= w_signed && (src_a[31] ^ src_b[31]) && (|src_b);
                r_rneg   <= w_signed && src_a[31];
            end else if (r_state == ST_MUL) begin
                r_acc <= {w_mul_sum, r_acc[31:1]};
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_go && w_mul_op) begin
`ifdef FAST_MUL_EN
                    w_state_nxt = ST_DONE;
`else
                    w_state_nxt = ST_MUL;
`endif
                end else if (w_div_start) begin
                    w_state_nxt = ST_DIV;
                end
            end
            ST_MUL: begin
                if (flush) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == C_LAST) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DIV: begin
                if (flush) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_div_done) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_prod   = r_neg ? (~r_acc + 64'd1) : r_acc;
    assign w_res_lo = r_is_div ? (r_qneg ? (~w_quot + 32'd1) : w_quot) : w_prod[31:0];
    assign w_res_hi = r_is_div ? (r_rneg ? (~w_rem + 32'd1) : w_rem) : w_prod[63:32];

    always_comb begin
        w_wb = '0;
        if ((r_state == ST_DONE) && resetn && !flush) begin
            w_wb = {1'b1, 1'b1, w_res_hi, w_res_lo};
        end else if (w_go && (op == MD_OP_MTHI)) begin
            w_wb = {1'b1, 1'b0, src_a, 32'd0};
        end else if (w_go && (op == MD_OP_MTLO)) begin
            w_wb = {1'b0, 1'b1, 32'd0, src_a};
        end
    end

    assign {hi_we, lo_we, hi_wdata, lo_wdata} = w_wb;

    assign stallreq = (w_go && (w_mul_op || w_div_op)) ||
                      (r_state == ST_MUL) || (r_state == ST_DIV);
    assign busy     = !w_idle;

endmodule
`default_nettype wire

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
Multi-cycle multiply/divide unit in EX that produces the HI/LO write port (hi_we, lo_we, hi_wdata, lo_wdata) consumed by the register file.
Executes MULT/MULTU/DIV/DIVU iteratively and handles MTHI/MTLO as single-cycle writes.
Raises a stall request to the pipeline control while an iterative operation is in flight.

Parameters:
ITER, 32, iteration cycles per mul/div (equals operand width; fixed at 32 for the MIPS word).

Ports:
clk  input  1  clock; all state updates on posedge
resetn  input  1  synchronous active-low reset, sampled on posedge clk
flush  input  1  pipeline flush; aborts any in-flight op
start  input  1  EX-stage request valid
op  input  3  operation code, MD_OP_* (see Decomposition)
src_a  input  32  rs value (dividend / multiplicand / MTHI-MTLO data)
src_b  input  32  rt value (divisor / multiplier)
stallreq  output  1  stall the pipeline front while op executes
busy  output  1  FSM not in IDLE
hi_we  output  1  HI write enable
lo_we  output  1  LO write enable
hi_wdata  output  32  HI write data
lo_wdata  output  32  LO write data

Behaviour:
- Reset (resetn=0 at posedge): FSM→IDLE, counters and datapath registers cleared. Every output reads 0 in the following cycle. Takes priority over flush and start.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE, start=1, op=MULT/MULTU (cycle T):
  - Operands latched.
  - Signed ops: absolute values latched, result-sign flags recorded.
  - →MUL. stallreq=1 combinationally in T.
- IDLE, start=1, op=DIV/DIVU: same as above, →DIV.
- MUL: shift-add on 32-bit magnitudes into a 64-bit accumulator. One bit per cycle, ITER cycles (T+1..T+32), then →DONE.
- DIV: restoring division with a 33-bit partial remainder. One quotient bit per cycle, ITER cycles, then →DONE.
- DONE (T+33):
  - hi_we=lo_we=1 for exactly one cycle. stallreq=0, busy=1. →IDLE.
  - MUL result: {hi,lo} = 64-bit product, two's-complement negated if sign flag set.
  - DIV result: lo = quotient, hi = remainder.
  - Signed divide: quotient negative iff operand signs differ; remainder takes the sign of the dividend.
- stallreq = (IDLE & start & op∈{MUL,DIV class}) | MUL | DIV. busy = state≠IDLE.
- MTHI/MTLO in IDLE:
  - Same-cycle combinational write. MTHI: hi_we=1, hi_wdata=src_a, lo_we=0. MTLO: mirror image.
  - No stall, no state change.
- start while busy: ignored; the pipeline is stalled, so EX holds the request.
- Divide by zero: no exception. Result is lo=32'hFFFFFFFF, hi=dividend, for both signed and unsigned.
- Signed edge case: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wrap).
- flush=1 in MUL/DIV/DONE:
  - →IDLE next cycle; no HI/LO write in that cycle or after.
  - A flush in the DONE cycle suppresses hi_we/lo_we.
  - A flush in IDLE with start suppresses the start and the MTHI/MTLO write.
- Write outputs are 0 whenever the corresponding we is 0.

Optional Feature:
FAST_MUL_EN
- Defined: MULT/MULTU use a single-cycle combinational 32x32 multiply. IDLE→DONE directly, so the write occurs at T+1 and stallreq is high only in T. DIV is unchanged.
- Undefined: iterative multiply as above (33-cycle latency), no hardware multiplier inferred.

Decomposition:
- defines.vh holds:
  - MD_OP_* codes: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - FSM state encodings.
  - Shared bus width constant for the EX→regfile HI/LO write bundle (we+data, 66 bits).
- Sub-module div_core:
  - Iterative unsigned restoring divider.
  - Interface: start, dividend, divisor, done, quot, rem.
  - Sign handling stays in hilo_muldiv.

Test Plan:
1. MULTU src_a=0xFFFFFFFF, src_b=0xFFFFFFFF at T → stallreq high T..T+32; at T+33 hi_we=lo_we=1, hi=0xFFFFFFFE, lo=0x00000001.
2. MULT -3 (0xFFFFFFFD) × 5 → DONE gives hi=0xFFFFFFFF, lo=0xFFFFFFF1.
3. DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 → lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
4. DIVU 0x1234/0 → lo=0xFFFFFFFF, hi=0x00001234, no hang; busy drops after DONE.
5. DIV started at T, flush at T+10 → no hi_we/lo_we through T+40, busy=0 at T+11. A new MULTU at T+12 is accepted and completes normally.
6. resetn low at T+5 of a DIV → all outputs 0 next cycle. Then MTHI src_a=0x1234 → same-cycle hi_we=1, hi_wdata=0x1234, lo_we=0, stallreq=0.
